// File: rtl/telemetry_pkg.sv
// -----------------------------------------------------------------------------
// telemetry_pkg
//   Shared definitions for the telemetry frame sequencer:
//     - tx_state_e   : frame FSM state encoding
//     - snapshot_t   : temperature/data words latched when a trigger is accepted
//     - FRAME_LEN_*  : frame lengths with and without the checksum byte
//     - IDX_*        : byte positions within a frame (checksum-enabled layout)
// -----------------------------------------------------------------------------
package telemetry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_ACK  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic [15:0] temperature;
        logic [23:0] data;
    } snapshot_t;

    localparam int FRAME_LEN_CHK   = 10;
    localparam int FRAME_LEN_NOCHK = 9;

    // Byte positions with the checksum present. Without the checksum the
    // trailer slides down by one; the byte mux handles that remap.
    localparam logic [3:0] IDX_HDR0 = 4'd0;
    localparam logic [3:0] IDX_HDR1 = 4'd1;
    localparam logic [3:0] IDX_T0   = 4'd2;
    localparam logic [3:0] IDX_T1   = 4'd3;
    localparam logic [3:0] IDX_D0   = 4'd4;
    localparam logic [3:0] IDX_D1   = 4'd5;
    localparam logic [3:0] IDX_D2   = 4'd6;
    localparam logic [3:0] IDX_CHK  = 4'd7;
    localparam logic [3:0] IDX_TR0  = 4'd8;
    localparam logic [3:0] IDX_TR1  = 4'd9;

    localparam logic [3:0] IDX_LAST_CHK   = 4'(FRAME_LEN_CHK - 1);
    localparam logic [3:0] IDX_LAST_NOCHK = 4'(FRAME_LEN_NOCHK - 1);

    // XOR of the five payload bytes.
    function automatic logic [7:0] payload_xor(input snapshot_t s);
        return s.temperature[7:0] ^ s.temperature[15:8] ^
               s.data[7:0] ^ s.data[15:8] ^ s.data[23:16];
    endfunction

endpackage : telemetry_pkg

// File: rtl/telemetry_byte_mux.sv
// -----------------------------------------------------------------------------
// telemetry_byte_mux
//   Combinational frame-byte selector.
//   Ports:
//     idx        in  4   byte index within the frame (0..LAST)
//     snap       in  40  latched temperature/data snapshot
//     frame_byte out 8   byte to transmit at position idx
//   With CHECKSUM_EN=0 indices at or above the checksum slot are shifted up by
//   one so the trailer follows the payload directly.
// -----------------------------------------------------------------------------
module telemetry_byte_mux
    import telemetry_pkg::*;
#(
    parameter logic [7:0] HDR0        = 8'h61,
    parameter logic [7:0] HDR1        = 8'h62,
    parameter bit         CHECKSUM_EN = 1'b1,
    parameter logic [7:0] TRAILER0    = 8'h0D,
    parameter logic [7:0] TRAILER1    = 8'h0A
) (
    input  logic [3:0] idx,
    input  snapshot_t  snap,
    output logic [7:0] frame_byte
);

    logic [3:0] eff_idx;
    logic [7:0] chk;

    assign chk = payload_xor(snap);

    always_comb begin
        eff_idx = idx;
        if (!CHECKSUM_EN && (idx >= IDX_CHK)) begin
            eff_idx = idx + 4'd1;
        end
    end

    always_comb begin
        frame_byte = 8'h00;
        case (eff_idx)
            IDX_HDR0: frame_byte = HDR0;
            IDX_HDR1: frame_byte = HDR1;
            IDX_T0:   frame_byte = snap.temperature[7:0];
            IDX_T1:   frame_byte = snap.temperature[15:8];
            IDX_D0:   frame_byte = snap.data[7:0];
            IDX_D1:   frame_byte = snap.data[15:8];
            IDX_D2:   frame_byte = snap.data[23:16];
            IDX_CHK:  frame_byte = chk;
            IDX_TR0:  frame_byte = TRAILER0;
            IDX_TR1:  frame_byte = TRAILER1;
            default:  frame_byte = 8'h00;
        endcase
    end

endmodule : telemetry_byte_mux

// File: rtl/telemetry_frame_tx.sv
// -----------------------------------------------------------------------------
// telemetry_frame_tx
//   Frame sequencer feeding async_transmitter. A trigger snapshots temperature
//   and data, then the frame (header, payload, optional XOR checksum, trailer)
//   is handed over one byte at a time with a tx_start/tx_busy handshake.
//   Ports:
//     clk, rst_n    clock / async active-low reset
//     trigger       one-cycle sample-ready pulse
//     temperature   16-bit raw temperature word
//     data          24-bit raw scratch word
//     overrun_clr   clears the sticky overrun flag
//     tx_busy       transmitter busy
//     tx_start      one-cycle start strobe to the transmitter
//     tx_data       byte to transmit, held until the next tx_start
//     frame_busy    frame in progress (trigger accepted .. frame_done)
//     frame_done    one-cycle pulse once the last byte has been sent
//     overrun       sticky: trigger seen while a frame was in progress
// -----------------------------------------------------------------------------
module telemetry_frame_tx
    import telemetry_pkg::*;
#(
    parameter logic [7:0] HDR0        = 8'h61,
    parameter logic [7:0] HDR1        = 8'h62,
    parameter bit         CHECKSUM_EN = 1'b1,
    parameter logic [7:0] TRAILER0    = 8'h0D,
    parameter logic [7:0] TRAILER1    = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [15:0] temperature,
    input  logic [23:0] data,
    input  logic        overrun_clr,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [3:0] LAST = CHECKSUM_EN ? IDX_LAST_CHK : IDX_LAST_NOCHK;

    tx_state_e  state;
    logic [3:0] idx;
    snapshot_t  snap;
    logic [7:0] frame_byte;

    telemetry_byte_mux #(
        .HDR0        (HDR0),
        .HDR1        (HDR1),
        .CHECKSUM_EN (CHECKSUM_EN),
        .TRAILER0    (TRAILER0),
        .TRAILER1    (TRAILER1)
    ) u_byte_mux (
        .idx        (idx),
        .snap       (snap),
        .frame_byte (frame_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            snap       <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;

            // frame_busy is still high in DONE, so a trigger there is an
            // overrun too. Setting beats clearing.
            if (trigger && frame_busy) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        snap.temperature <= temperature;
                        snap.data        <= data;
                        idx              <= 4'd0;
                        frame_busy       <= 1'b1;
                        state            <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_byte;
                        state    <= ST_ACK;
                    end
                end
                // The transmitter raises busy one cycle after start; skip
                // looking at it here so the stale low isn't taken as done.
                ST_ACK: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (idx == LAST) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    frame_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : telemetry_frame_tx

// File: tb/tb_telemetry_frame_tx.sv
// Bench for telemetry_frame_tx: one instance with checksum, one without, each
// driving its own transmitter model. Frames are checked against byte lists
// built directly from the frame layout.
module tb_telemetry_frame_tx;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  trig = 2'b00;
    logic [15:0] temp = 16'h0;
    logic [23:0] dat = 24'h0;
    logic        ovr_clr = 1'b0;
    logic        hold = 1'b0;

    logic       busy_a, busy_b;
    logic       start_a, start_b, fbusy_a, fbusy_b, fdone_a, fdone_b, ovr_a, ovr_b;
    logic [7:0] data_a, data_b;

    int n_chk = 0;
    int n_err = 0;

    // transmitter model state, written only by the monitor process
    int      busy_cnt [2];
    int      bt = 2;
    int      done_cnt [2];
    int      consec [2];
    int      unstable [2];
    logic    prev_st [2];
    logic [7:0] held [2];
    byte_q_t rx_a, rx_b;

    logic exp_ovr_a = 1'b0;
    logic exp_ovr_b = 1'b0;

    always #5 clk = ~clk;

    assign busy_a = hold || (busy_cnt[0] != 0);
    assign busy_b = hold || (busy_cnt[1] != 0);

    telemetry_frame_tx #(.CHECKSUM_EN(1'b1)) u_dut_chk (
        .clk(clk), .rst_n(rst_n), .trigger(trig[0]), .temperature(temp), .data(dat),
        .overrun_clr(ovr_clr), .tx_busy(busy_a), .tx_start(start_a), .tx_data(data_a),
        .frame_busy(fbusy_a), .frame_done(fdone_a), .overrun(ovr_a)
    );

    telemetry_frame_tx #(.CHECKSUM_EN(1'b0)) u_dut_nochk (
        .clk(clk), .rst_n(rst_n), .trigger(trig[1]), .temperature(temp), .data(dat),
        .overrun_clr(ovr_clr), .tx_busy(busy_b), .tx_start(start_b), .tx_data(data_b),
        .frame_busy(fbusy_b), .frame_done(fdone_b), .overrun(ovr_b)
    );

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; done_cnt[i] = 0; consec[i] = 0;
            unstable[i] = 0; prev_st[i] = 1'b0; held[i] = 8'h00;
        end
    end

    // Transmitter model + protocol monitor; busy rises on the clock after start.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       st, fd;
            logic [7:0] d;
            st = (i == 0) ? start_a : start_b;
            fd = (i == 0) ? fdone_a : fdone_b;
            d  = (i == 0) ? data_a  : data_b;
            if (st) begin
                if (prev_st[i]) consec[i]++;
                if (i == 0) rx_a.push_back(d); else rx_b.push_back(d);
                busy_cnt[i] = bt;
                held[i] = d;
            end else begin
                if (busy_cnt[i] != 0) busy_cnt[i]--;
                if (!rst_n) held[i] = d;
                else if (d != held[i]) unstable[i]++;
            end
            if (fd) done_cnt[i]++;
            prev_st[i] = st;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_exp(input logic [15:0] t, input logic [23:0] d,
                                      input bit ce, output byte_q_t f);
        logic [7:0] pay [5];
        logic [7:0] x;
        pay = '{t[7:0], t[15:8], d[7:0], d[15:8], d[23:16]};
        f = {};
        f.push_back(8'h61);
        f.push_back(8'h62);
        x = 8'h00;
        foreach (pay[k]) begin
            f.push_back(pay[k]);
            x = x ^ pay[k];
        end
        if (ce) f.push_back(x);
        f.push_back(8'h0D);
        f.push_back(8'h0A);
    endfunction

    task automatic check_frames(input logic [15:0] t, input logic [23:0] d);
        byte_q_t ea, eb;
        build_exp(t, d, 1'b1, ea);
        build_exp(t, d, 1'b0, eb);
        chk("len_chk", rx_a.size(), ea.size());
        for (int k = 0; k < ea.size() && k < rx_a.size(); k++)
            chk($sformatf("byte_chk[%0d]", k), rx_a[k], ea[k]);
        chk("len_nochk", rx_b.size(), eb.size());
        for (int k = 0; k < eb.size() && k < rx_b.size(); k++)
            chk($sformatf("byte_nochk[%0d]", k), rx_b[k], eb[k]);
    endtask

    // mode: 0 plain, 1 inputs change mid-frame, 2 re-trigger (with clear) mid-frame,
    // 3 busy held 50 clocks, 4 re-trigger during DONE (checksum instance),
    // 5 trigger together with overrun_clr
    task automatic run_frame(input logic [15:0] t, input logic [23:0] d, input int mode);
        int  base_a, base_b, guard;
        bit  fired;
        base_a = done_cnt[0];
        base_b = done_cnt[1];
        fired = 1'b0;
        rx_a.delete();
        rx_b.delete();
        temp = t;
        dat = d;
        if (mode == 3) hold = 1'b1;
        trig = 2'b11;
        if (mode == 5) ovr_clr = 1'b1;
        @(negedge clk);
        trig = 2'b00;
        ovr_clr = 1'b0;
        chk("frame_busy_a", fbusy_a, 1'b1);
        chk("frame_busy_b", fbusy_b, 1'b1);
        if (mode == 5) begin
            chk("ovr_clr_trig_a", ovr_a, 1'b0);
            exp_ovr_a = 1'b0;
            exp_ovr_b = 1'b0;
        end
        if (mode == 3) begin
            repeat (50) @(negedge clk);
            chk("hold_no_start_a", rx_a.size(), 0);
            chk("hold_no_start_b", rx_b.size(), 0);
            hold = 1'b0;
            @(negedge clk);
            chk("hold_start_a", start_a, 1'b1);
            chk("hold_byte_a", data_a, 8'h61);
            chk("hold_start_b", start_b, 1'b1);
        end
        guard = 0;
        while ((done_cnt[0] == base_a || done_cnt[1] == base_b) && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (mode == 1 && rx_a.size() >= 2) begin
                temp = 16'hFFFF;
                dat = 24'h000000;
            end
            if (mode == 2 && !fired && rx_a.size() == 4) begin
                trig = 2'b11;
                ovr_clr = 1'b1;
                @(negedge clk);
                trig = 2'b00;
                ovr_clr = 1'b0;
                fired = 1'b1;
                exp_ovr_a = 1'b1;
                exp_ovr_b = 1'b1;
                chk("ovr_set_wins_a", ovr_a, 1'b1);
                chk("ovr_set_wins_b", ovr_b, 1'b1);
            end
            if (mode == 4 && !fired && fdone_a) begin
                trig = 2'b01;
                @(negedge clk);
                trig = 2'b00;
                fired = 1'b1;
                exp_ovr_a = 1'b1;
            end
        end
        chk("frame_timeout", (guard < 3000), 1'b1);
        repeat (20) @(negedge clk);
        check_frames(t, d);
        chk("done_once_a", done_cnt[0] - base_a, 1);
        chk("done_once_b", done_cnt[1] - base_b, 1);
        chk("idle_busy_a", fbusy_a, 1'b0);
        chk("overrun_a", ovr_a, exp_ovr_a);
        chk("overrun_b", ovr_b, exp_ovr_b);
    endtask

    task automatic reset_mid_frame();
        int guard;
        rx_a.delete();
        rx_b.delete();
        temp = 16'h1234;
        dat = 24'h56789A;
        trig = 2'b11;
        @(negedge clk);
        trig = 2'b00;
        guard = 0;
        while (rx_a.size() < 5 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_reach_byte5", (guard < 1000), 1'b1);
        @(negedge clk);   // now in WAIT with the model still busy
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_start", start_a, 1'b0);
        chk("rst_frame_busy", fbusy_a, 1'b0);
        chk("rst_tx_data", data_a, 8'h00);
        chk("rst_tx_data_b", data_b, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_ovr_a = 1'b0;
        exp_ovr_b = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_resume", start_a | fbusy_a, 1'b0);
    endtask

    initial begin
        #2;
        chk("reset_start_a", start_a, 1'b0);
        chk("reset_data_a", data_a, 8'h00);
        chk("reset_fbusy_a", fbusy_a, 1'b0);
        chk("reset_fdone_a", fdone_a, 1'b0);
        chk("reset_ovr_a", ovr_a, 1'b0);
        chk("reset_start_b", start_b, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        bt = 2;
        run_frame(16'h0191, 24'hA53C0F, 0);
        run_frame(16'h0191, 24'hA53C0F, 1);
        bt = 3;
        run_frame(16'(($urandom)), 24'($urandom), 2);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        exp_ovr_a = 1'b0;
        exp_ovr_b = 1'b0;
        chk("ovr_clr_a", ovr_a, 1'b0);
        chk("ovr_clr_b", ovr_b, 1'b0);
        run_frame(16'(($urandom)), 24'($urandom), 0);
        run_frame(16'h0191, 24'hA53C0F, 3);
        run_frame(16'(($urandom)), 24'($urandom), 4);
        run_frame(16'(($urandom)), 24'($urandom), 5);

        bt = 3;
        reset_mid_frame();
        run_frame(16'h0191, 24'hA53C0F, 0);

        for (int n = 0; n < 6; n++) begin
            bt = int'($urandom_range(1, 6));
            run_frame(16'(($urandom)), 24'($urandom), int'($urandom_range(0, 1)));
        end

        chk("no_back_to_back_a", consec[0], 0);
        chk("no_back_to_back_b", consec[1], 0);
        chk("tx_data_stable_a", unstable[0], 0);
        chk("tx_data_stable_b", unstable[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // hard stop in case something above never returns
    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_telemetry_frame_tx
